// File: rtl/extend_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : extend_arbiter_pkg
// Description : Shared definitions for the immediate-extension arbiter.
//               Holds the extension mode encodings and the default widths.
// Ports       : none (package)
// Options     : EXTEND_ARB_FIXED_PRIO_EN is consumed by extend_arbiter and
//               rr_arbiter2, not by this package.
// Revision    : 1.0 - initial release
// ============================================================================
package extend_arbiter_pkg;

  // Extension mode encodings carried on reqN_mode.
  localparam logic [1:0] EXT_SIGN = 2'b00;  // sign-extend to DATA_W
  localparam logic [1:0] EXT_ZERO = 2'b01;  // zero-extend to DATA_W
  localparam logic [1:0] EXT_HIGH = 2'b10;  // imm in the top bits, low bits zero
  localparam logic [1:0] EXT_RSVD = 2'b11;  // reserved, result is all zeros

  // Default widths.
  localparam int IMM_W_DEFAULT  = 16;
  localparam int DATA_W_DEFAULT = 32;

endpackage : extend_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way combinational arbiter with one-hot grant.
//               Round-robin by default: on contention the requester that was
//               not granted last wins. With EXTEND_ARB_FIXED_PRIO_EN defined,
//               req0 always wins and the last_grant_i port is removed.
// Ports       : req0_i, req1_i  - request lines
//               enable_i        - no grant is issued while low
//               last_grant_i    - 0: req0 granted last, 1: req1 granted last
//               grant_o[1:0]    - one-hot grant, bit N for requester N
// Options     : EXTEND_ARB_FIXED_PRIO_EN
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       enable_i,
`ifndef EXTEND_ARB_FIXED_PRIO_EN
  input  logic       last_grant_i,
`endif
  output logic [1:0] grant_o
);

`ifdef EXTEND_ARB_FIXED_PRIO_EN
  assign grant_o[0] = enable_i & req0_i;
  assign grant_o[1] = enable_i & req1_i & ~req0_i;
`else
  // On contention, last_grant_i=1 hands the slot to req0, otherwise to req1.
  assign grant_o[0] = enable_i & req0_i & (~req1_i |  last_grant_i);
  assign grant_o[1] = enable_i & req1_i & (~req0_i | ~last_grant_i);
`endif

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/extend_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : extend_arbiter
// Description : Arbitrates two immediate-extension requesters into a single
//               registered output slot. The granted immediate is sign-,
//               zero- or high-extended to DATA_W and presented one cycle
//               after the transfer. The slot refills in the same cycle it
//               drains, so one result per cycle is sustained.
// Ports       : clock, reset                  - clock, sync active-high reset
//               reqN_valid/ready/mode/imm     - requester N (N = 0, 1)
//               out_valid/ready/data/src      - result handshake
// Options     : EXTEND_ARB_FIXED_PRIO_EN - req0 always wins contention and
//               the last_grant register is not built.
// Revision    : 1.0 - initial release
// ============================================================================
module extend_arbiter
  import extend_arbiter_pkg::*;
#(
  parameter int IMM_W  = IMM_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_mode,
  input  logic [IMM_W-1:0]  req0_imm,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_mode,
  input  logic [IMM_W-1:0]  req1_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
);

  function automatic logic [DATA_W-1:0] extend_imm(input logic [1:0]       mode,
                                                   input logic [IMM_W-1:0] imm);
    case (mode)
      EXT_SIGN: return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_ZERO: return {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_HIGH: return {imm, {(DATA_W-IMM_W){1'b0}}};
      default:  return '0;
    endcase
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_src_q,   out_src_d;

  logic              w_slot_free;
  logic              w_enable;
  logic [1:0]        w_grant;
  logic              w_xfer;
  logic [1:0]        w_sel_mode;
  logic [IMM_W-1:0]  w_sel_imm;

  // Slot is free when empty or when the consumer drains it this cycle.
  assign w_slot_free = ~out_valid_q | out_ready;
  // Readys are forced low during reset so no transfer is ever seen then.
  assign w_enable    = w_slot_free & ~reset;

`ifdef EXTEND_ARB_FIXED_PRIO_EN
  rr_arbiter2 u_arb (
    .req0_i   (req0_valid),
    .req1_i   (req1_valid),
    .enable_i (w_enable),
    .grant_o  (w_grant)
  );
`else
  logic last_grant_q, last_grant_d;

  rr_arbiter2 u_arb (
    .req0_i       (req0_valid),
    .req1_i       (req1_valid),
    .enable_i     (w_enable),
    .last_grant_i (last_grant_q),
    .grant_o      (w_grant)
  );

  // Only a completed transfer moves the round-robin pointer.
  assign last_grant_d = w_xfer ? w_grant[1] : last_grant_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;  // req0 wins the first contention after reset
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_xfer     = |w_grant;

  assign w_sel_mode = w_grant[1] ? req1_mode : req0_mode;
  assign w_sel_imm  = w_grant[1] ? req1_imm  : req0_imm;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = extend_imm(w_sel_mode, w_sel_imm);
      out_src_d   = w_grant[1];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule : extend_arbiter
`default_nettype wire

// File: tb/tb_extend_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_extend_arbiter
// Description : Self-checking bench for extend_arbiter. A directed vector
//               table covers reset, each extension mode, contention, stall
//               with same-cycle refill and reset during a pending result;
//               a randomized phase follows, checked against a transaction
//               level model of the arbitration and extension rules.
// Options     : honours EXTEND_ARB_FIXED_PRIO_EN for expected winners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_extend_arbiter;

`ifdef EXTEND_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_mode, req1_mode;
  logic [15:0] req0_imm, req1_imm;
  logic        out_valid, out_ready, out_src;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  extend_arbiter #(.IMM_W(16), .DATA_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_mode  (req0_mode),
    .req0_imm   (req0_imm),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_mode  (req1_mode),
    .req1_imm   (req1_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [1:0]  m0;
    logic [15:0] i0;
    logic        v1;
    logic [1:0]  m1;
    logic [15:0] i1;
    logic        ordy;
    logic [1:0]  exp_rdy;  // {req1_ready, req0_ready} before the edge
    logic        exp_ov;
    logic        chk_d;    // compare data/src after the edge
    logic [31:0] exp_d;
    logic        exp_s;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference extension computed arithmetically from the mode rules.
  function automatic logic [31:0] ext_ref(input logic [1:0] mode, input logic [15:0] imm);
    int unsigned v;
    v = imm;
    case (mode)
      2'd0:    return (v >= 32768) ? v + 32'hFFFF0000 : v;
      2'd1:    return v;
      2'd2:    return v * 65536;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic v0, input logic [1:0] m0, input logic [15:0] i0,
                       input logic v1, input logic [1:0] m1, input logic [15:0] i1, input logic ordy);
    reset = rst; req0_valid = v0; req0_mode = m0; req0_imm = i0;
    req1_valid = v1; req1_mode = m1; req1_imm = i1; out_ready = ordy;
  endtask

  // Transaction-level model state
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_src;
  int          m_last;  // index of the last requester granted

  initial begin
    logic [1:0] rr_w, rr_d_sel;
    logic [31:0] rr_d;
    rr_w = FIXED ? 2'b01 : 2'b10;
    rr_d = FIXED ? 32'h1 : 32'h8000;
    rr_d_sel = 2'b00;

    //                rst   v0    m0     i0         v1    m1     i1         ordy  rdy    ov    chk   data           src
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 16'hF00F, 1'b0, 2'd0, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 16'hF00F, 1'b0, 2'd0, 16'h0000, 1'b1, 2'b01, 1'b1, 1'b1, 32'hFFFFF00F,  1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 16'hF00F, 1'b1, 2'b10, 1'b1, 1'b1, 32'h0000F00F,  1'b1};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 16'hF00F, 1'b1, 2'b10, 1'b1, 1'b1, 32'hF00F0000,  1'b1};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 2'd3, 16'hF00F, 1'b1, 2'b10, 1'b1, 1'b1, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0};
    // Contention, both valid, consumer always ready
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b1, 2'b01, 1'b1, 1'b1, 32'h1,         1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b1, rr_w,  1'b1, 1'b1, rr_d,          rr_w[1]};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b1, 2'b01, 1'b1, 1'b1, 32'h1,         1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b1, rr_w,  1'b1, 1'b1, rr_d,          rr_w[1]};
    // Stall: result held, no readys
    vecs[11] = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b0, rr_d_sel, 1'b1, 1'b1, rr_d,       rr_w[1]};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b0, rr_d_sel, 1'b1, 1'b1, rr_d,       rr_w[1]};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b0, rr_d_sel, 1'b1, 1'b1, rr_d,       rr_w[1]};
    // Drain and refill in the same cycle
    vecs[14] = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b1, 2'b01, 1'b1, 1'b1, 32'h1,         1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b0, 2'b00, 1'b1, 1'b1, 32'h1,         1'b0};
    // Reset while a result is pending, then contention goes to req0
    vecs[16] = '{1'b1, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0,         1'b0};
    vecs[17] = '{1'b0, 1'b1, 2'd0, 16'h0001, 1'b1, 2'd1, 16'h8000, 1'b0, 2'b01, 1'b1, 1'b1, 32'h1,         1'b0};

    drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    @(posedge clock); #1;

    // ---------------- directed vectors ----------------
    for (int k = 0; k < NVEC; k++) begin
      drive(vecs[k].rst, vecs[k].v0, vecs[k].m0, vecs[k].i0,
            vecs[k].v1, vecs[k].m1, vecs[k].i1, vecs[k].ordy);
      #3;
      check($sformatf("vec%0d readys", k), {30'd0, req1_ready, req0_ready}, {30'd0, vecs[k].exp_rdy});
      @(posedge clock); #1;
      check($sformatf("vec%0d out_valid", k), {31'd0, out_valid}, {31'd0, vecs[k].exp_ov});
      if (vecs[k].chk_d) begin
        check($sformatf("vec%0d out_data", k), out_data, vecs[k].exp_d);
        check($sformatf("vec%0d out_src", k), {31'd0, out_src}, {31'd0, vecs[k].exp_s});
      end
    end

    // ---------------- randomized phase against the model ----------------
    drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    @(posedge clock); #1;
    m_valid = 1'b0; m_data = 32'd0; m_src = 1'b0; m_last = 1;

    for (int c = 0; c < 1500; c++) begin
      logic        rst, v0, v1, ordy, free;
      logic [1:0]  m0, m1;
      logic [15:0] i0, i1;
      int          win;
      rst  = ($urandom_range(0, 63) == 0);
      v0   = $urandom_range(0, 1) == 1;
      v1   = $urandom_range(0, 1) == 1;
      ordy = $urandom_range(0, 3) != 0;
      m0   = 2'($urandom_range(0, 3));
      m1   = 2'($urandom_range(0, 3));
      i0   = 16'($urandom);
      i1   = 16'($urandom);
      drive(rst, v0, m0, i0, v1, m1, i1, ordy);

      free = !m_valid || ordy;
      win  = -1;
      if (!rst && free) begin
        if (v0 && v1)  win = FIXED ? 0 : 1 - m_last;
        else if (v0)   win = 0;
        else if (v1)   win = 1;
      end
      #3;
      check("rand req0_ready", {31'd0, req0_ready}, (win == 0) ? 32'd1 : 32'd0);
      check("rand req1_ready", {31'd0, req1_ready}, (win == 1) ? 32'd1 : 32'd0);

      @(posedge clock); #1;
      if (rst) begin
        m_valid = 1'b0; m_data = 32'd0; m_src = 1'b0; m_last = 1;
      end else if (win >= 0) begin
        m_valid = 1'b1;
        m_data  = (win == 0) ? ext_ref(m0, i0) : ext_ref(m1, i1);
        m_src   = (win == 1);
        m_last  = win;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      check("rand out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid || rst) begin
        check("rand out_data", out_data, m_data);
        check("rand out_src", {31'd0, out_src}, {31'd0, m_src});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_extend_arbiter
`default_nettype wire

// File: doc/extend_arbiter.md
EXTEND_ARBITER -- requirements
Module: extend_arbiter

Interface
REQ-001 The block SHALL have parameter IMM_W, default 16, immediate field width.
REQ-002 The block SHALL have parameter DATA_W, default 32, extended result width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 req0_valid  input  1  requester 0 (decode: branch/jump offsets) has an immediate.
REQ-006 req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-007 req0_mode  input  2  requester 0 extension mode.
REQ-008 req0_imm  input  IMM_W  requester 0 immediate.
REQ-009 req1_valid, req1_ready, req1_mode, req1_imm: same directions, widths and meanings as REQ-005..008, for requester 1 (ALU immediate operands).
REQ-010 out_valid  output  1  extended result held in the output register.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_data  output  DATA_W  extended result.
REQ-013 out_src  output  1  requester index that produced out_data.

Function
REQ-014 Modes SHALL be: 00 sign-extend imm to DATA_W; 01 zero-extend; 10 imm placed in bits [DATA_W-1:DATA_W-IMM_W], low bits zero; 11 reserved, result all zeros.
REQ-015 Transfer on a port SHALL occur when its valid and ready are both high on a rising edge.
REQ-016 The single output slot SHALL be free when out_valid is 0, or when out_valid and out_ready are both 1 (same-cycle drain and refill).
REQ-017 The readys SHALL be combinational from the valids, slot state and last_grant; at most one ready is high per cycle, and only when the slot is free.
REQ-018 With one requester valid and the slot free, that requester SHALL be granted.
REQ-019 With both valid and the slot free, the requester not granted last SHALL win (round-robin); last_grant updates only on a transfer.
REQ-020 Latency SHALL be one cycle: the result of a transfer at edge N appears on out_data/out_src with out_valid=1 after edge N.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_src SHALL hold stable and both readys SHALL be 0.
REQ-022 out_valid SHALL fall after an edge with out_ready=1 and no new transfer.
REQ-023 With back-to-back traffic and out_ready held at 1, the block SHALL sustain one result per cycle.
REQ-024 A requester's valid dropping without a transfer SHALL have no effect on state.

Reset
REQ-025 While reset=1 at an edge: out_valid=0, out_data=0, out_src=0, last_grant=1 (req0 wins the first contention).
REQ-026 req0_ready and req1_ready SHALL be 0 in any cycle where reset=1.
REQ-027 A reset asserted while a result is pending SHALL discard the result with no further handshake.

Configuration
REQ-028 Macro EXTEND_ARB_FIXED_PRIO_EN SHALL be the only compile option.
REQ-029 When the macro is defined, req0 SHALL always win contention and last_grant SHALL be absent.
REQ-030 When the macro is undefined, arbitration SHALL be round-robin per REQ-019.

Structure
REQ-031 A shared package/include SHALL hold the mode encodings (EXT_SIGN=00, EXT_ZERO=01, EXT_HIGH=10, EXT_RSVD=11) and the default widths.
REQ-032 The grant logic SHALL be a sub-module rr_arbiter2 (inputs: two requests, enable, last_grant; outputs: one-hot grant).
REQ-033 Extension and the output register SHALL stay in extend_arbiter.

Verification
REQ-034 Apply reset for 2 cycles -> out_valid=0, out_data=0, out_src=0, both readys 0.
REQ-035 Only req0_valid, mode=00, imm=16'hF00F, out_ready=1 -> req0_ready=1; next cycle out_data=32'hFFFFF00F, out_src=0.
REQ-036 Only req1_valid, mode=01 then 10, imm=16'hF00F -> out_data=32'h0000F00F, then 32'hF00F0000; mode=11 -> 32'h0.
REQ-037 Both valid for 4 cycles, out_ready=1 -> out_src sequence 0,1,0,1 (round-robin build); 0,0,0,0 with EXTEND_ARB_FIXED_PRIO_EN.
REQ-038 out_ready=0 for 3 cycles with both valid -> result held, readys 0; on out_ready=1, same-cycle refill, one transfer per cycle.
REQ-039 Assert reset while out_valid=1 and out_ready=0 -> out_valid=0 next cycle; the next contention is granted to req0.
